zero_cross_pitch: RTL and testbench



---
 rtl/zero_cross_pitch.sv | 113 +++++++++++
 tb/tb_zero_cross_pitch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/zero_cross_pitch.sv
// Pitch-period estimator: measures the distance between hysteresis-qualified
// rising zero crossings, averages groups of accepted periods and flags silence.
module zero_cross_pitch #(
  parameter int unsigned HYST       = 8,
  parameter int unsigned MIN_PERIOD = 8,
  parameter int unsigned MAX_PERIOD = 2047,
  parameter int unsigned AVG_LOG2   = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        audio_valid_in,
  input  logic [7:0]  audio_in,
  output logic [15:0] period_out,
  output logic        period_valid_out,
  output logic        silent_out
);

  // cnt must reach MAX_PERIOD and p = cnt+1 must still compare above it
  localparam int unsigned CW    = $clog2(MAX_PERIOD + 2);
  localparam int unsigned SW    = $clog2(MAX_PERIOD + 1) + AVG_LOG2;
  localparam int unsigned KW    = AVG_LOG2 + 1;
  localparam int unsigned GROUP = 1 << AVG_LOG2;

  localparam logic signed [9:0] HI_TH = 10'(HYST);
  localparam logic signed [9:0] LO_TH = -HI_TH;

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t        state;
  logic          have_ref;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sum;
  logic [KW-1:0] k;

  logic signed [9:0] sample;
  logic              is_high;
  logic              is_low;
  logic              rise;
  logic [CW-1:0]     p;
  logic              p_short;
  logic              p_long;
  logic [SW-1:0]     sum_acc;
  logic [KW-1:0]     k_inc;
  logic              group_done;

  // Sample classification and crossing / period arithmetic
  always_comb begin
    sample     = 10'(signed'(audio_in));
    is_high    = sample >= HI_TH;
    is_low     = sample <= LO_TH;
    rise       = audio_valid_in && (state == LOW) && is_high;
    p          = cnt + CW'(1);
    p_short    = p < CW'(MIN_PERIOD);
    p_long     = p > CW'(MAX_PERIOD);
    sum_acc    = sum + SW'(p);
    k_inc      = k + KW'(1);
    group_done = (k_inc == KW'(GROUP));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= IDLE;
      have_ref         <= 1'b0;
      cnt              <= '0;
      sum              <= '0;
      k                <= '0;
      period_out       <= '0;
      period_valid_out <= 1'b0;
      silent_out       <= 1'b1;
    end else begin
      period_valid_out <= 1'b0;
      if (audio_valid_in) begin
        case (state)
          IDLE:    if (is_low)  state <= LOW;
          LOW:     if (is_high) state <= HIGH;
          HIGH:    if (is_low)  state <= LOW;
          default: state <= IDLE;
        endcase

        if (rise) begin
          // Over-long period with a reference in hand just restarts the reference
          if (!have_ref || p_long) begin
            have_ref <= 1'b1;
            cnt      <= '0;
          end else if (p_short) begin
            cnt <= p;
          end else begin
            cnt <= '0;
            if (group_done) begin
              period_out       <= 16'(sum_acc >> AVG_LOG2);
              period_valid_out <= 1'b1;
              silent_out       <= 1'b0;
              sum              <= '0;
              k                <= '0;
            end else begin
              sum <= sum_acc;
              k   <= k_inc;
            end
          end
        end else if (p_long) begin
          // Silence timeout: drop reference and partial group, hold cnt
          have_ref   <= 1'b0;
          sum        <= '0;
          k          <= '0;
          silent_out <= 1'b1;
        end else begin
          cnt <= p;
        end
      end
    end
  end

endmodule

// File: tb/tb_zero_cross_pitch.sv
// Directed bench for zero_cross_pitch: square waves, hysteresis boundary,
// averaging/truncation, glitch rejection, silence timeout and reset.
module tb_zero_cross_pitch;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [7:0]  audio;
  logic [15:0] period;
  logic        pv;
  logic        silent;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          strobes  = 0;
  int          dbl      = 0;
  int          gap      = 8;
  int          s0;
  logic [15:0] last_period = '0;
  logic        prev_v = 1'b0;

  always #5 clk = ~clk;

  zero_cross_pitch dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .audio_valid_in   (valid),
    .audio_in         (audio),
    .period_out       (period),
    .period_valid_out (pv),
    .silent_out       (silent)
  );

  // Strobe monitor: counts pulses, captures the strobed period, flags back-to-back pulses
  always @(negedge clk) begin
    if (pv) begin
      strobes     = strobes + 1;
      last_period = period;
      if (prev_v) dbl = dbl + 1;
    end
    prev_v = pv;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called in the low clock phase; one valid cycle then gap-1 idle cycles
  task automatic send(input logic [7:0] x);
    valid = 1'b1;
    audio = x;
    @(negedge clk);
    valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_n(input logic [7:0] x, input int n);
    for (int i = 0; i < n; i++) send(x);
  endtask

  // One period starting with the high half; glitch_at replaces that high sample with lo
  task automatic hcycle(input int per, input logic [7:0] hi, input logic [7:0] lo,
                        input int glitch_at);
    for (int i = 0; i < per / 2; i++) send((i == glitch_at) ? lo : hi);
    for (int i = per / 2; i < per; i++) send(lo);
  endtask

  task automatic hcycles(input int per, input int n);
    for (int i = 0; i < n; i++) hcycle(per, 8'd64, 8'hC0, -1);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    audio = '0;
    @(negedge clk);
    do_reset(2);
    check("reset_period", 32'(period), 32'd0);
    check("reset_valid", 32'(pv), 32'd0);
    check("reset_silent", 32'(silent), 32'd1);

    // 20-sample square, one valid every 8 cycles
    send(8'hC0);
    hcycles(20, 4);
    settle();
    check("sq_no_strobe_before_5th", 32'(strobes), 32'd0);
    check("sq_silent_before_lock", 32'(silent), 32'd1);
    send(8'd64);
    settle();
    check("sq_first_strobe", 32'(strobes), 32'd1);
    check("sq_first_period", 32'(last_period), 32'd20);
    check("sq_silent_locked", 32'(silent), 32'd0);
    send_n(8'd64, 9);
    send_n(8'hC0, 10);
    hcycles(20, 3);
    send(8'd64);
    settle();
    check("sq_second_strobe", 32'(strobes), 32'd2);
    check("sq_second_period", 32'(last_period), 32'd20);

    // Silence timeout: 2047 zeros still locked, the 2048th times out
    send_n(8'd0, 2047);
    settle();
    check("to_not_yet_silent", 32'(silent), 32'd0);
    send(8'd0);
    settle();
    check("to_silent", 32'(silent), 32'd1);
    check("to_no_strobe", 32'(strobes), 32'd2);
    check("to_period_held", 32'(period), 32'd20);
    send(8'hC0);
    hcycles(20, 4);
    settle();
    check("resume_no_early_strobe", 32'(strobes), 32'd2);
    send(8'd64);
    settle();
    check("resume_strobe", 32'(strobes), 32'd3);
    check("resume_period", 32'(last_period), 32'd20);

    // Reset in the middle of a group discards the partial sum
    send_n(8'd64, 9);
    send_n(8'hC0, 10);
    hcycles(20, 1);
    do_reset(1);
    check("midrst_period", 32'(period), 32'd0);
    check("midrst_valid", 32'(pv), 32'd0);
    check("midrst_silent", 32'(silent), 32'd1);
    s0 = strobes;
    send(8'hC0);
    hcycles(20, 4);
    send(8'd64);
    settle();
    check("midrst_regroup_strobes", 32'(strobes), 32'(s0 + 1));
    check("midrst_regroup_period", 32'(last_period), 32'd20);

    // Sub-hysteresis tones never lock
    do_reset(1);
    s0 = strobes;
    for (int a = 5; a <= 7; a += 2) begin
      for (int i = 0; i < 3; i++) hcycle(20, 8'(a), 8'(-a), -1);
    end
    settle();
    check("subhyst_no_strobe", 32'(strobes), 32'(s0));
    check("subhyst_silent", 32'(silent), 32'd1);

    // Alternating periods average to 20
    do_reset(1);
    s0 = strobes;
    send(8'hC0);
    hcycle(18, 8'd64, 8'hC0, -1);
    hcycle(22, 8'd64, 8'hC0, -1);
    hcycle(18, 8'd64, 8'hC0, -1);
    hcycle(22, 8'd64, 8'hC0, -1);
    send(8'd64);
    settle();
    check("alt_strobe", 32'(strobes), 32'(s0 + 1));
    check("alt_period", 32'(last_period), 32'd20);

    // 19,19,19,20 truncates to 19; amplitude exactly at the threshold
    do_reset(1);
    s0 = strobes;
    send(8'hF8);
    for (int i = 0; i < 3; i++) hcycle(19, 8'd8, 8'hF8, -1);
    hcycle(20, 8'd8, 8'hF8, -1);
    send(8'd8);
    settle();
    check("trunc_strobe", 32'(strobes), 32'(s0 + 1));
    check("trunc_period", 32'(last_period), 32'd19);

    // Glitch pair giving p=4 inside a 40-sample wave; lows at -128
    do_reset(1);
    s0 = strobes;
    send(8'h80);
    hcycle(40, 8'd64, 8'h80, -1);
    hcycle(40, 8'd64, 8'h80, 3);
    hcycle(40, 8'd64, 8'h80, -1);
    hcycle(40, 8'd64, 8'h80, -1);
    settle();
    check("glitch_no_early_strobe", 32'(strobes), 32'(s0));
    send(8'd64);
    settle();
    check("glitch_strobe", 32'(strobes), 32'(s0 + 1));
    check("glitch_period", 32'(last_period), 32'd40);

    // Back-to-back samples at full rate
    gap = 1;
    do_reset(1);
    s0 = strobes;
    send(8'hC0);
    hcycles(20, 4);
    send(8'd64);
    settle();
    check("b2b_strobe", 32'(strobes), 32'(s0 + 1));
    check("b2b_period", 32'(last_period), 32'd20);
    check("b2b_silent", 32'(silent), 32'd0);

    check("no_double_strobe", 32'(dbl), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
